top_mult_int7b: RTL and testbench
=================================

# top_mult_int7b

Signed 7-bit by constant multiplier, module `top_mult_int7b`, serving as the arithmetic top of the int7 multiplier test circuit. It accepts one signed 7-bit operand per clock, multiplies it by a compile-time signed coefficient using a shift-add (CSD) network, and presents the full-precision 14-bit signed product through a two-stage register pipeline. An optional approximate mode truncates low product bits for area and energy savings.

## Interface
- Reset is asynchronous and active-low, with one clock: `clk` and `rst_n`.
- `BIT_WIDTH`, default 7: operand width, two's complement.
- `OUT_WIDTH`, default `2*BIT_WIDTH` = 14: product width.
- `COEFF`, default 45: signed constant multiplier; legal range -64..63.
- `TRUNC_BITS`, default 4: low product bits dropped in approximate mode; legal range 0..OUT_WIDTH-1.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: `inp` carries a sample this cycle.
- `inp`  in  7: signed operand.
- `out_valid`  out  1: `out` holds a product.
- `out`  out  14: signed product.

## Operation
- Stage 1: on each rising clock edge, register `inp` and `in_valid`.
- Stage 2: compute the product of the stage-1 operand and `COEFF`, then register the result and the valid flag.
- Product value: `out` = `inp`*`COEFF`, exact, two's complement.
  - Worst case is (-64)*(-64) = 4096, which fits in 14 bits, so overflow and saturation are impossible.
- Multiplier structure: a fixed CSD shift-add/subtract network derived from `COEFF`. No generic `*` operator is required. Sign extension must be applied to every partial product.
- `COEFF` = 0: `out` is constantly 0 whenever `out_valid` is 1.
- Bubble handling: when `in_valid` = 0, the pipeline still advances and `out_valid` becomes 0 two cycles later. `out` holds its previous value while `out_valid` = 0.
- There is no backpressure. A new sample is accepted every cycle.

## Timing
- Latency: a sample presented before rising edge N appears on `out` after edge N+1, i.e. 2 cycles. Throughput is 1 sample per cycle.
- Reset: when `rst_n` goes low, all pipeline registers clear immediately, regardless of the clock.
  - Outputs during reset: `out` = 0, `out_valid` = 0.
- Reset mid-stream: in-flight samples are discarded and never emitted.
- Reset release: the first sample is accepted at the first rising edge with `rst_n` = 1.
- Output timing: `out` and `out_valid` change only on clock edges or on reset assertion. There are no combinational paths from input to output.

## Configuration
- Macro: `MULT_APPROX_TRUNC_EN`.
- Defined: `out` = floor(`inp`*`COEFF` / 2^`TRUNC_BITS`) * 2^`TRUNC_BITS`.
  - The low `TRUNC_BITS` bits are forced to 0 (arithmetic shift right, then shift left).
  - Partial-product logic for those bits may be removed.
- Undefined: the product is exact. `TRUNC_BITS` is ignored.
- Latency and reset behaviour are identical in both modes.

## Test plan
- Reset check: hold `rst_n` = 0 while driving `inp` = 63 and `in_valid` = 1 -> `out` = 0 and `out_valid` = 0. Release reset -> `out` = 2835 and `out_valid` = 1 exactly 2 cycles later.
- Exact mode with `COEFF` = 45: drive the stream 1, -1, 0, -64 back-to-back -> `out` reads 45, -45, 0, -2880 (14'h34C0) on consecutive cycles starting at cycle 2.
- Extremes: sweep all 128 values of `inp` with `COEFF` set to -64, 63 and 0 -> `out` matches the signed reference product each cycle, with no overflow.
- Bubble: drive `in_valid` pattern 1,0,1 with `inp` 2,99,3 -> `out_valid` pattern 1,0,1 with `out` 90, 90 held, 135.
- Mid-stream reset: assert `rst_n` asynchronously between edges while 2 samples are in flight -> `out` goes to 0 immediately, and neither sample is emitted after release.
- Approximate mode with `MULT_APPROX_TRUNC_EN` defined, `TRUNC_BITS` = 4, `COEFF` = 45: drive `inp` = 1, -1, 63 -> `out` = 32, -48, 2832.

Source files
------------

// File: rtl/top_mult_int7b.sv
// Signed BIT_WIDTH x constant COEFF multiplier built from a CSD shift-add network, two-stage pipeline.
// Optional `MULT_APPROX_TRUNC_EN clears the low TRUNC_BITS of the product (floor to a multiple of 2^TRUNC_BITS).
module top_mult_int7b #(
  parameter int BIT_WIDTH  = 7,
  parameter int OUT_WIDTH  = 2 * BIT_WIDTH,
  parameter int COEFF      = 45,
  parameter int TRUNC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] inp,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out
);

  // A BIT_WIDTH-bit signed coefficient needs at most BIT_WIDTH+1 CSD digits.
  localparam int NDIG = BIT_WIDTH + 1;

  function automatic logic [NDIG-1:0] csd_digits(input int coeff, input bit want_neg);
    logic [NDIG-1:0] pos;
    logic [NDIG-1:0] neg;
    int c;
    pos = '0;
    neg = '0;
    c   = coeff;
    for (int i = 0; i < NDIG; i++) begin
      if (c[0]) begin
        if (c[1]) begin
          neg[i] = 1'b1;
          c      = c + 1;
        end else begin
          pos[i] = 1'b1;
          c      = c - 1;
        end
      end
      c = c >>> 1;
    end
    return want_neg ? neg : pos;
  endfunction

  localparam logic [NDIG-1:0] POS_DIG = csd_digits(COEFF, 1'b0);
  localparam logic [NDIG-1:0] NEG_DIG = csd_digits(COEFF, 1'b1);

`ifdef MULT_APPROX_TRUNC_EN
  localparam int TRUNC_EFF = TRUNC_BITS;
`else
  localparam int TRUNC_EFF = TRUNC_BITS * 0;
`endif
  localparam logic [OUT_WIDTH-1:0] KEEP_MASK = {OUT_WIDTH{1'b1}} << TRUNC_EFF;

  logic [BIT_WIDTH-1:0] op_q;
  logic                 vld_q;
  logic [OUT_WIDTH-1:0] op_ext;
  logic [OUT_WIDTH-1:0] prod;

  assign op_ext = {{(OUT_WIDTH-BIT_WIDTH){op_q[BIT_WIDTH-1]}}, op_q};

  // Modulo-2^OUT_WIDTH accumulation is exact because the final product always fits.
  always_comb begin
    prod = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (POS_DIG[i]) prod = prod + (op_ext << i);
      if (NEG_DIG[i]) prod = prod - (op_ext << i);
    end
    prod = prod & KEEP_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      vld_q     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      op_q      <= inp;
      vld_q     <= in_valid;
      out_valid <= vld_q;
      if (vld_q) out <= prod;
    end
  end

endmodule

// File: tb/tb_top_mult_int7b.sv
// Directed self-checking bench for top_mult_int7b; extra instances cover COEFF = -64, 63 and 0.
module tb_top_mult_int7b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  inp;
  logic        out_valid, v_n64, v_63, v_0;
  logic [13:0] out, o_n64, o_63, o_0;

  int total = 0;
  int bad   = 0;

  top_mult_int7b #(.COEFF(45)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp), .out_valid(out_valid), .out(out));
  top_mult_int7b #(.COEFF(-64)) dut_n64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp), .out_valid(v_n64), .out(o_n64));
  top_mult_int7b #(.COEFF(63)) dut_63 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp), .out_valid(v_63), .out(o_63));
  top_mult_int7b #(.COEFF(0)) dut_0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inp(inp), .out_valid(v_0), .out(o_0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact product, optionally floored to a multiple of 16.
  function automatic logic [13:0] model(int p);
    logic [13:0] r;
    r = 14'(p);
`ifdef MULT_APPROX_TRUNC_EN
    r = r & 14'h3FF0;
`endif
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; inp = 7'd63;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out !== 14'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hold: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_latency1: valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (out !== model(2835) || out_valid !== 1'b1) begin
      bad++; $display("FAIL reset_first: out=%0d valid=%b expected out=%0d valid=1", out, out_valid, model(2835));
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_exact_stream();
    int xs [4] = '{1, -1, 0, -64};
    int es [4] = '{45, -45, 0, -2880};
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 4);
      inp      = (i < 4) ? 7'(xs[i]) : 7'd0;
      @(posedge clk); #1;
      if (i >= 1) begin
        total++;
        if (out !== model(es[i-1]) || out_valid !== 1'b1) begin
          bad++; $display("FAIL stream[%0d]: out=%h valid=%b expected out=%h valid=1", i-1, out, out_valid, model(es[i-1]));
        end
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    int x;
    for (int i = 0; i <= 128; i++) begin
      in_valid = (i < 128);
      inp      = 7'(i - 64);
      @(posedge clk); #1;
      if (i >= 1) begin
        x = i - 65;
        total++;
        if (o_n64 !== model(x * -64) || v_n64 !== 1'b1) begin
          bad++; $display("FAIL sweep_n64 x=%0d: out=%h expected %h", x, o_n64, model(x * -64));
        end
        total++;
        if (o_63 !== model(x * 63) || v_63 !== 1'b1) begin
          bad++; $display("FAIL sweep_63 x=%0d: out=%h expected %h", x, o_63, model(x * 63));
        end
        total++;
        if (o_0 !== 14'd0 || v_0 !== 1'b1) begin
          bad++; $display("FAIL sweep_0 x=%0d: out=%h expected 0", x, o_0);
        end
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_bubble();
    logic vin [3] = '{1'b1, 1'b0, 1'b1};
    int   xs  [3] = '{2, 99, 3};
    int   es  [3] = '{90, 90, 135};
    logic ev  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3) ? vin[i] : 1'b0;
      inp      = (i < 3) ? 7'(xs[i]) : 7'd0;
      @(posedge clk); #1;
      if (i >= 1) begin
        total++;
        if (out !== model(es[i-1]) || out_valid !== ev[i-1]) begin
          bad++; $display("FAIL bubble[%0d]: out=%0d valid=%b expected out=%0d valid=%b",
                          i-1, out, out_valid, model(es[i-1]), ev[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1; inp = 7'd5;
    @(posedge clk); #1;
    inp = 7'd6;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out !== 14'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_async: out=%0d valid=%b expected out=0 valid=0", out, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || out !== 14'd0) begin
        bad++; $display("FAIL midreset_drop[%0d]: out=%0d valid=%b expected out=0 valid=0", i, out, out_valid);
      end
    end
  endtask

  task automatic test_approx();
    int xs [3] = '{1, -1, 63};
`ifdef MULT_APPROX_TRUNC_EN
    int es [3] = '{32, -48, 2832};
`else
    int es [3] = '{45, -45, 2835};
`endif
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 3);
      inp      = (i < 3) ? 7'(xs[i]) : 7'd0;
      @(posedge clk); #1;
      if (i >= 1) begin
        total++;
        if (out !== 14'(es[i-1]) || out_valid !== 1'b1) begin
          bad++; $display("FAIL approx[%0d]: out=%0d valid=%b expected out=%0d valid=1", i-1, out, out_valid, 14'(es[i-1]));
        end
      end
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inp = '0;
    test_reset();
    test_exact_stream();
    test_sweep();
    test_bubble();
    test_midstream_reset();
    test_approx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
